// File: rtl/gat_bram_load_ctrl.sv
// rtl/gat_bram_load_ctrl.sv - BRAM write-path translation, per-channel load tracking and GAT layer launch control
module gat_bram_load_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 18,
  parameter int BYTE_SHIFT = 2,
  parameter int CNT_W      = 20
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                wr_ena,
  input  logic [NUM_CH-1:0]                wr_wea,
  input  logic [NUM_CH*(ADDR_W+BYTE_SHIFT)-1:0] wr_addr_byte,
  input  logic [NUM_CH*CNT_W-1:0]          exp_count,
  input  logic [NUM_CH-1:0]                sw_load_done,
  input  logic                             start,
  input  logic                             layer_in,
  input  logic                             abort,
  input  logic                             clr_err,
  input  logic                             core_ready,
  output logic [NUM_CH-1:0]                bram_en,
  output logic [NUM_CH-1:0]                bram_we,
  output logic [NUM_CH*ADDR_W-1:0]         bram_addr,
  output logic                             core_start,
  output logic                             core_layer,
  output logic                             busy,
  output logic [NUM_CH-1:0]                ch_done,
  output logic [1:0]                       err,
  output logic [31:0]                      run_cycles,
  output logic                             done
);

  localparam int BA_W = ADDR_W + BYTE_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] ch_done_d;
  logic [1:0]        err_set;
  logic              wr_ok, clr_cnt, launch, complete, ready_q;

  assign wr_ok   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign clr_cnt = abort || (state_q == S_DONE);
  assign busy    = (state_q == S_ARMED) || (state_q == S_RUN);

  // ch_done is computed from the next count so it lands one cycle after the write
  always_comb begin
    accept  = '0;
    err_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (wr_ena[c] && wr_wea[c]) begin
        if (wr_addr_byte[c*BA_W +: BYTE_SHIFT] != '0) err_set[0] = 1'b1;
        if (!wr_ok) err_set[1] = 1'b1;
        accept[c] = wr_ok && (wr_addr_byte[c*BA_W +: BYTE_SHIFT] == '0);
      end
      if (clr_cnt)
        cnt_d[c] = '0;
      else if (accept[c] && (cnt_q[c] != '1))
        cnt_d[c] = cnt_q[c] + {{(CNT_W-1){1'b0}}, 1'b1};
      ch_done_d[c] = sw_load_done[c] ||
                     ((exp_count[c*CNT_W +: CNT_W] != '0) && (cnt_d[c] >= exp_count[c*CNT_W +: CNT_W]));
    end
  end

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (&ch_done)     state_d = S_ARMED;
        else if (|accept) state_d = S_LOAD;
      end
      S_LOAD:  if (&ch_done) state_d = S_ARMED;
      S_ARMED: begin
        if (start) begin
          launch  = 1'b1;
          state_d = S_RUN;
        end
      end
      // the launch cycle itself never completes, so a ready level held across launch is ignored
      S_RUN: begin
        if (core_ready && !ready_q && !core_start) begin
          complete = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      launch   = 1'b0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      bram_en    <= '0;
      bram_we    <= '0;
      bram_addr  <= '0;
      ch_done    <= '0;
      core_start <= 1'b0;
      core_layer <= 1'b0;
      err        <= '0;
      run_cycles <= '0;
      done       <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        bram_addr[c*ADDR_W +: ADDR_W] <= wr_addr_byte[c*BA_W + BYTE_SHIFT +: ADDR_W];
      end
      bram_en    <= wr_ena;
      bram_we    <= accept;
      ch_done    <= ch_done_d;
      core_start <= launch;
      done       <= complete;
      ready_q    <= core_ready;
      err        <= (clr_err ? 2'b00 : err) | err_set;
      if (launch) begin
        core_layer <= layer_in;
        run_cycles <= '0;
      end else if ((state_q == S_RUN) && !abort && (run_cycles != '1)) begin
        run_cycles <= run_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// tb/tb_gat_bram_load_ctrl.sv - self-checking bench for gat_bram_load_ctrl
module tb_gat_bram_load_ctrl;
  localparam int NCH  = 4;
  localparam int AW   = 18;
  localparam int BS   = 2;
  localparam int CW   = 10;
  localparam int BAW  = AW + BS;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0]     wr_ena = '0, wr_wea = '0, sw_load_done = '0;
  logic [NCH*BAW-1:0] wr_addr_byte = '0;
  logic [NCH*CW-1:0]  exp_count = '0;
  logic start = 1'b0, layer_in = 1'b0, abort = 1'b0, clr_err = 1'b0, core_ready = 1'b1;
  logic [NCH-1:0]     bram_en, bram_we, ch_done;
  logic [NCH*AW-1:0]  bram_addr;
  logic               core_start, core_layer, busy, done;
  logic [1:0]         err;
  logic [31:0]        run_cycles;

  always #5 clk = ~clk;

  gat_bram_load_ctrl #(.NUM_CH(NCH), .ADDR_W(AW), .BYTE_SHIFT(BS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_wea(wr_wea), .wr_addr_byte(wr_addr_byte),
    .exp_count(exp_count), .sw_load_done(sw_load_done), .start(start), .layer_in(layer_in),
    .abort(abort), .clr_err(clr_err), .core_ready(core_ready), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .core_start(core_start), .core_layer(core_layer),
    .busy(busy), .ch_done(ch_done), .err(err), .run_cycles(run_cycles), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int m_cnt [NCH];
  logic [1:0] m_err;
  bit m_wr_ok;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cycle of PS writes using the current wr_addr_byte; expectations from the write rules.
  task automatic drive_cycle(input string tag, input logic [NCH-1:0] ena, input logic [NCH-1:0] wea);
    logic [NCH-1:0]    exp_we;
    logic [NCH*AW-1:0] exp_addr;
    int a;
    exp_we = '0;
    if (clr_err) m_err = 2'b00;
    for (int c = 0; c < NCH; c++) begin
      a = int'(wr_addr_byte[c*BAW +: BAW]);
      exp_addr[c*AW +: AW] = AW'(a / (1 << BS));
      if (ena[c] && wea[c]) begin
        if (a % (1 << BS) != 0) m_err[0] = 1'b1;
        if (!m_wr_ok) m_err[1] = 1'b1;
        if ((a % (1 << BS) == 0) && m_wr_ok) begin
          exp_we[c] = 1'b1;
          if (m_cnt[c] < CMAX) m_cnt[c]++;
        end
      end
    end
    wr_ena = ena;
    wr_wea = wea;
    tick();
    chk({tag, "_en"},   bram_en,   ena);
    chk({tag, "_we"},   bram_we,   exp_we);
    chk({tag, "_addr"}, bram_addr, exp_addr);
    chk({tag, "_err"},  err,       m_err);
    wr_ena = '0;
    wr_wea = '0;
  endtask

  // Reads the hidden write count through ch_done by moving exp_count around the model value.
  task automatic probe_cnt(input string tag, input int c);
    logic [NCH*CW-1:0] saved;
    saved = exp_count;
    if (m_cnt[c] > 0) begin
      exp_count[c*CW +: CW] = CW'(m_cnt[c]);
      tick();
      chk({tag, "_ge"}, ch_done[c], 1'b1);
    end
    if (m_cnt[c] < CMAX) begin
      exp_count[c*CW +: CW] = CW'(m_cnt[c] + 1);
      tick();
      chk({tag, "_lt"}, ch_done[c], 1'b0);
    end
    exp_count = saved;
    tick();
  endtask

  task automatic set_addr(input int c, input int a);
    wr_addr_byte[c*BAW +: BAW] = BAW'(a);
  endtask

  task automatic model_clear_cnt;
    for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int run_len, n0, n1, hold;
    logic [NCH-1:0] ena_r, wea_r;
    model_clear_cnt();
    m_err   = 2'b00;
    m_wr_ok = 1'b1;

    repeat (2) tick();
    chk("rst_en_we",  {bram_en, bram_we}, '0);
    chk("rst_addr",   bram_addr, '0);
    chk("rst_ctrl",   {core_start, core_layer, busy, done}, '0);
    chk("rst_chdone", ch_done, '0);
    chk("rst_err",    err, '0);
    chk("rst_run",    run_cycles, '0);
    rst_n = 1'b1;
    tick();

    set_addr(1, 'h0000C);
    drive_cycle("wr_ch1", 4'b0010, 4'b0010);
    chk("wr_ch1_word", bram_addr[AW +: AW], 18'd3);
    probe_cnt("cnt_ch1", 1);

    set_addr(1, 'h0000D);
    drive_cycle("misalign", 4'b0010, 4'b0010);
    clr_err = 1'b1;
    drive_cycle("clr_err", '0, '0);
    clr_err = 1'b0;
    drive_cycle("misalign2", 4'b0010, 4'b0010);
    clr_err = 1'b1;
    drive_cycle("clr_vs_err", 4'b0010, 4'b0010);
    drive_cycle("clr_err2", '0, '0);
    clr_err = 1'b0;

    for (int i = 0; i < 60; i++) begin
      for (int c = 0; c < NCH; c++) begin
        int a;
        a = int'($urandom_range(0, (1 << BAW) - 1));
        if ($urandom_range(0, 3) != 0) a = a & ~((1 << BS) - 1);
        set_addr(c, a);
      end
      ena_r = NCH'($urandom);
      wea_r = NCH'($urandom);
      drive_cycle("rnd", ena_r, wea_r);
    end
    chk("rnd_chdone", ch_done, '0);
    chk("rnd_busy", busy, 1'b0);
    for (int c = 0; c < NCH; c++) probe_cnt("rnd_cnt", c);
    clr_err = 1'b1;
    drive_cycle("rnd_clr", '0, '0);
    clr_err = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_clear_cnt();
    chk("abort_load_busy", busy, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_idle", core_start, 1'b0);
    tick();
    chk("start_idle_busy", {core_start, busy}, 2'b00);

    exp_count = '0;
    exp_count[0 +: CW]  = CW'(3);
    exp_count[CW +: CW] = CW'(5);
    n0 = 0;
    n1 = 0;
    while (n0 < 3 || n1 < 5) begin
      int c;
      c = (n0 >= 3) ? 1 : (n1 >= 5) ? 0 : int'($urandom_range(0, 1));
      set_addr(c, int'($urandom_range(0, (1 << AW) - 1)) * (1 << BS));
      drive_cycle("arm_wr", NCH'(1 << c), NCH'(1 << c));
      if (c == 0) n0++; else n1++;
    end
    chk("arm_chdone_lo", ch_done, 4'b0011);
    sw_load_done = 4'b1100;
    tick();
    chk("arm_chdone_all", ch_done, 4'hF);
    chk("arm_busy_pre", busy, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("armed_busy", busy, 1'b1);
    chk("armed_entry_start", core_start, 1'b0);
    tick();
    chk("armed_hold", {core_start, busy}, 2'b01);

    run_len = int'($urandom_range(4, 30));
    layer_in = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    layer_in = 1'b0;
    chk("launch_start", core_start, 1'b1);
    chk("launch_layer", core_layer, 1'b1);
    chk("launch_busy", busy, 1'b1);
    for (int k = 1; k <= run_len; k++) begin
      core_ready = (k == run_len);
      if (k == 1) exp_count[0 +: CW] = CW'(4);
      if (k == 2) begin
        m_wr_ok = 1'b0;
        set_addr(0, 'h00040);
        drive_cycle("run_wr", 4'b0001, 4'b0001);
        chk("run_cnt_hold", ch_done[0], 1'b0);
      end else begin
        tick();
      end
      chk("run_start_pulse", core_start, 1'b0);
      chk("run_done", done, k == run_len);
      chk("run_busy", busy, k != run_len);
    end
    chk("run_cycles", run_cycles, 32'(run_len));
    tick();
    chk("post_done", {done, busy}, 2'b00);
    chk("post_run_hold", run_cycles, 32'(run_len));
    chk("post_cnt_clr", ch_done, 4'b1100);
    model_clear_cnt();
    m_wr_ok = 1'b1;
    clr_err = 1'b1;
    drive_cycle("post_clr", '0, '0);
    clr_err = 1'b0;

    exp_count = '0;
    sw_load_done = '0;
    tick();
    set_addr(2, 'h00100);
    drive_cycle("ab_wr", 4'b0100, 4'b0100);
    drive_cycle("ab_wr", 4'b0100, 4'b0100);
    sw_load_done = 4'hF;
    tick();
    tick();
    chk("ab_armed", busy, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_launch", {core_start, core_layer}, 2'b10);
    hold = int'($urandom_range(3, 12));
    for (int j = 1; j <= hold; j++) begin
      tick();
      chk("ab_ready_high", {done, busy}, 2'b01);
    end
    sw_load_done = '0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_clear_cnt();
    chk("ab_idle", {busy, core_start, done}, 3'b000);
    chk("ab_run_keep", run_cycles, 32'(hold));
    probe_cnt("ab_cnt", 2);

    set_addr(3, 'h00007);
    drive_cycle("rs_err", 4'b1000, 4'b1000);
    sw_load_done = 4'hF;
    tick();
    tick();
    layer_in = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rs_running", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_busy", busy, 1'b0);
    chk("rs_cleared", {ch_done, err, core_layer, core_start}, '0);
    chk("rs_run", run_cycles, '0);
    sw_load_done = '0;
    layer_in = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear_cnt();
    m_err = 2'b00;
    tick();

    set_addr(3, 'h00100);
    wr_ena = 4'b1000;
    wr_wea = 4'b1000;
    for (int i = 0; i < CMAX + 3; i++) begin
      tick();
      if (m_cnt[3] < CMAX) m_cnt[3]++;
    end
    wr_ena = '0;
    wr_wea = '0;
    probe_cnt("sat", 3);
    chk("sat_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gat_bram_load_ctrl.md
Name: gat_bram_load_ctrl

Overview:
Parametrised load/launch controller between the PS-side BRAM write ports and the GAT core. It generalises byte-to-word address translation to NUM_CH channels and registers the translated write path. It counts accepted writes per channel, and gates the layer launch with a state machine. It then measures core run time and returns to idle on core completion.

Parameters:
NUM_CH, 4, number of BRAM write channels (H data, node info, weight, spare)
ADDR_W, 18, word-address width per channel
BYTE_SHIFT, 2, log2 bytes per word; byte address width = ADDR_W+BYTE_SHIFT
CNT_W, 20, per-channel write-count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_ena  in  NUM_CH  per-channel enable from PS
wr_wea  in  NUM_CH  per-channel write enable from PS
wr_addr_byte  in  NUM_CH*(ADDR_W+BYTE_SHIFT)  packed byte addresses, ch0 in LSBs
exp_count  in  NUM_CH*CNT_W  expected write count per channel; 0 = count check disabled
sw_load_done  in  NUM_CH  register-bank load-done flags, level
start  in  1  launch request, single-cycle pulse
layer_in  in  1  layer select for the launch
abort  in  1  synchronous return to IDLE
clr_err  in  1  clears sticky error bits
core_ready  in  1  gat_ready from core
bram_en  out  NUM_CH  registered enable to BRAM
bram_we  out  NUM_CH  registered, qualified write enable
bram_addr  out  NUM_CH*ADDR_W  registered word addresses
core_start  out  1  one-cycle launch pulse
core_layer  out  1  layer captured at launch
busy  out  1  high in ARMED and RUN
ch_done  out  NUM_CH  per-channel load complete
err  out  2  sticky: [0] misaligned write, [1] write while ARMED/RUN
run_cycles  out  32  cycles from core_start to completion, held until next launch
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Address path, latency 1: bram_addr[ch] = wr_addr_byte[ch] >> BYTE_SHIFT, truncated to ADDR_W. bram_en[ch] = wr_ena[ch]. bram_we[ch] = wr_ena&wr_wea&aligned&write-allowed.
- aligned = low BYTE_SHIFT bits zero. A misaligned write is suppressed and sets err[0].
- Writes are allowed in IDLE and LOAD. A write in ARMED/RUN/DONE is suppressed and sets err[1].
- Accepted write: cnt[ch]+1, saturating at all-ones (no wrap).
- ch_done[ch] = sw_load_done[ch] | (exp_count[ch]!=0 & cnt[ch]>=exp_count[ch]). Registered; it updates the cycle after the qualifying write.
- States:
  - IDLE -> LOAD on the first accepted write.
  - IDLE/LOAD -> ARMED when &ch_done.
  - ARMED -> RUN on start: core_layer<=layer_in, core_start=1 for exactly 1 cycle, run_cycles<=0.
  - RUN: run_cycles+1 per cycle, saturating. Completion is a core_ready 0->1 transition sampled on cycles after core_start. A ready level already high at launch does not complete the run.
  - RUN -> DONE on completion: done=1 for 1 cycle.
  - DONE -> IDLE the next cycle; cnt cleared, run_cycles held.
- start outside ARMED is ignored. start coincident with the entry into ARMED is ignored.
- abort, any state: next cycle IDLE, cnt cleared, core_start forced 0. run_cycles and err are kept.
- clr_err clears err. If clr_err and a new error occur in the same cycle, the error wins.
- Reset mid-RUN: immediate IDLE, all cleared.

Test Plan:
- Aligned write ch1 byte addr 0x0000C, wea=1 -> next cycle bram_addr[ch1]=3, bram_we[1]=1, cnt1=1.
- Byte addr 0x0000D, wea=1 -> bram_we=0, err=2'b01; clr_err -> err=0.
- exp_count={0,0,5,3}: 3 writes ch0 and 5 writes ch1; set sw_load_done[3:2]=2'b11 -> ch_done=4'hF, ARMED, busy=1.
- In ARMED pulse start with layer_in=1 -> core_start is a 1-cycle pulse, core_layer=1. Drop core_ready at +1 and raise it at +10 -> done pulse; run_cycles=10 (±1 per the defined sampling), then IDLE.
- Write during RUN -> bram_we=0, err[1]=1, cnt unchanged. start in IDLE -> no core_start.
- abort during RUN, or rst_n low mid-RUN -> IDLE next cycle/immediately, busy=0, counters 0. Saturation: exp_count=0, 2^CNT_W+2 writes -> cnt stays all-ones.
